// File: rtl/time_set_ctrl.sv
// Clock/calendar time-of-day keeper with a three-state set mode (RUN, SET_HOUR, SET_MIN).
// All outputs come straight from registers; sequencing is one next-state block plus one register block.
module time_set_ctrl #(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_1hz_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  output logic [4:0] hour_o,
  output logic [5:0] min_o,
  output logic [5:0] sec_o,
  output logic [1:0] mode_o,
  output logic       blink_o,
  output logic       hour_tick_o,
  output logic       day_tick_o
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HOUR = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  localparam logic [4:0] INIT_HOUR_C = INIT_HOUR[4:0];
  localparam logic [5:0] INIT_MIN_C  = INIT_MIN[5:0];

  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [1:0] mode_q, mode_d;
  logic       blink_q, blink_d;
  logic       hour_tick_q, hour_tick_d;
  logic       day_tick_q, day_tick_d;

  logic       sec_wrap_s, min_wrap_s, hour_wrap_s;
  logic [4:0] hour_inc_s;
  logic [5:0] min_inc_s, sec_inc_s;

  // Wrap detection uses >= so a corrupted field still folds back into range.
  assign sec_wrap_s  = (sec_q  >= 6'd59);
  assign min_wrap_s  = (min_q  >= 6'd59);
  assign hour_wrap_s = (hour_q >= 5'd23);
  assign sec_inc_s   = sec_wrap_s  ? 6'd0 : sec_q  + 6'd1;
  assign min_inc_s   = min_wrap_s  ? 6'd0 : min_q  + 6'd1;
  assign hour_inc_s  = hour_wrap_s ? 5'd0 : hour_q + 5'd1;

  // Next-state: mode button beats increment, increment beats tick-driven blink toggle.
  always_comb begin
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    mode_d      = mode_q;
    blink_d     = blink_q;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    case (mode_q)
      ST_RUN: begin
        blink_d = 1'b1;
        if (tick_1hz_i) begin
          sec_d = sec_inc_s;
          if (sec_wrap_s) begin
            min_d = min_inc_s;
            if (min_wrap_s) begin
              hour_d      = hour_inc_s;
              hour_tick_d = 1'b1;
              day_tick_d  = hour_wrap_s;
            end else begin
              hour_d = hour_q;
            end
          end else begin
            min_d = min_q;
          end
        end else begin
          sec_d = sec_q;
        end
        if (mode_btn_i) begin
          mode_d = ST_SET_HOUR;
        end else begin
          mode_d = ST_RUN;
        end
      end
      ST_SET_HOUR: begin
        if (mode_btn_i) begin
          mode_d  = ST_SET_MIN;
          sec_d   = 6'd0;
          blink_d = 1'b1;
        end else if (inc_btn_i) begin
          hour_d  = hour_inc_s;
          blink_d = 1'b1;
        end else if (tick_1hz_i) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
      end
      ST_SET_MIN: begin
        sec_d = 6'd0;
        if (mode_btn_i) begin
          mode_d  = ST_RUN;
          blink_d = 1'b1;
        end else if (inc_btn_i) begin
          min_d   = min_inc_s;
          blink_d = 1'b1;
        end else if (tick_1hz_i) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
      end
      default: begin
        mode_d  = ST_RUN;
        blink_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hour_q      <= INIT_HOUR_C;
      min_q       <= INIT_MIN_C;
      sec_q       <= 6'd0;
      mode_q      <= ST_RUN;
      blink_q     <= 1'b1;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
    end else begin
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      mode_q      <= mode_d;
      blink_q     <= blink_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
    end
  end

  assign hour_o      = hour_q;
  assign min_o       = min_q;
  assign sec_o       = sec_q;
  assign mode_o      = mode_q;
  assign blink_o     = blink_q;
  assign hour_tick_o = hour_tick_q;
  assign day_tick_o  = day_tick_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: fixed vector table, directed corner sequences, then random
// stimulus against a seconds-of-day reference model.
module tb_time_set_ctrl;

  localparam int IH = 0;
  localparam int IM = 0;

  logic       clk = 1'b0;
  logic       rst, tick, mode_btn, inc;
  logic [4:0] hour_o;
  logic [5:0] min_o, sec_o;
  logic [1:0] mode_o;
  logic       blink_o, hour_tick_o, day_tick_o;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: time as seconds since midnight, mode as 0/1/2.
  int m_tod, m_mode, m_blink, m_ht, m_dt;

  time_set_ctrl #(.INIT_HOUR(IH), .INIT_MIN(IM)) dut (
    .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick), .mode_btn_i(mode_btn), .inc_btn_i(inc),
    .hour_o(hour_o), .min_o(min_o), .sec_o(sec_o), .mode_o(mode_o), .blink_o(blink_o),
    .hour_tick_o(hour_tick_o), .day_tick_o(day_tick_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, t, m, i;
    int   h, mi, s, md, b, ht, dt;
  } vec_t;

  vec_t tbl [16];

  task automatic model_step(input logic r, input logic t, input logic m, input logic i);
    int h, mn;
    if (r) begin
      m_tod = IH * 3600 + IM * 60; m_mode = 0; m_blink = 1; m_ht = 0; m_dt = 0;
    end else begin
      m_ht = 0; m_dt = 0;
      if (m_mode == 0) begin
        if (t) begin
          m_tod = (m_tod + 1) % 86400;
          m_ht  = (m_tod % 3600 == 0) ? 1 : 0;
          m_dt  = (m_tod == 0) ? 1 : 0;
        end
        if (m) m_mode = 1;
        m_blink = 1;
      end else if (m) begin
        if (m_mode == 1) m_tod = m_tod - (m_tod % 60);
        m_mode  = (m_mode + 1) % 3;
        m_blink = 1;
      end else if (i) begin
        h  = m_tod / 3600;
        mn = (m_tod / 60) % 60;
        if (m_mode == 1) h = (h + 1) % 24;
        else mn = (mn + 1) % 60;
        m_tod   = h * 3600 + mn * 60 + (m_tod % 60);
        m_blink = 1;
      end else if (t) begin
        m_blink = 1 - m_blink;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input int h, input int mi, input int s,
                         input int md, input int b, input int ht, input int dt);
    logic [21:0] got, exp;
    got = {hour_o, min_o, sec_o, mode_o, blink_o, hour_tick_o, day_tick_o};
    exp = {h[4:0], mi[5:0], s[5:0], md[1:0], b[0], ht[0], dt[0]};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d ht=%0d dt=%0d, expected %0d:%0d:%0d mode=%0d blink=%0d ht=%0d dt=%0d",
               name, hour_o, min_o, sec_o, mode_o, blink_o, hour_tick_o, day_tick_o,
               h, mi, s, md, b, ht, dt);
    end
  endtask

  task automatic apply(input logic r, input logic t, input logic m, input logic i);
    rst = r; tick = t; mode_btn = m; inc = i;
    @(posedge clk);
    #1;
    model_step(r, t, m, i);
    rst = 1'b0; tick = 1'b0; mode_btn = 1'b0; inc = 1'b0;
  endtask

  task automatic step(input logic r, input logic t, input logic m, input logic i, input string name);
    apply(r, t, m, i);
    chk_out(name, m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode, m_blink, m_ht, m_dt);
  endtask

  // From RUN: set hour and minute through the set states, then return to RUN.
  task automatic set_time(input int h, input int mn);
    int nh, nm;
    step(1'b0, 1'b0, 1'b1, 1'b0, "set_enter");
    nh = (h - m_tod / 3600 + 24) % 24;
    for (int k = 0; k < nh; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "set_hinc");
    step(1'b0, 1'b0, 1'b1, 1'b0, "set_tomin");
    nm = (mn - (m_tod / 60) % 60 + 60) % 60;
    for (int k = 0; k < nm; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "set_minc");
    step(1'b0, 1'b0, 1'b1, 1'b0, "set_exit");
  endtask

  initial begin
    int ht_cnt, ht_at;
    int bseq [4];
    rst = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc = 1'b0;
    m_tod = 0; m_mode = 0; m_blink = 1; m_ht = 0; m_dt = 0;
    bseq = '{0, 1, 0, 1};

    //                r     t     m     i     h  mi s  md b  ht dt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 2, 1, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 1, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2, 1, 1, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 2, 1, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 0, 2, 1, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 2, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1, 0, 2, 1, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 2, 1, 0, 0, 1, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1, 0, 1, 0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1, 0, 0};

    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      apply(tbl[k].r, tbl[k].t, tbl[k].m, tbl[k].i);
      chk_out($sformatf("tbl%0d", k), tbl[k].h, tbl[k].mi, tbl[k].s, tbl[k].md,
              tbl[k].b, tbl[k].ht, tbl[k].dt);
    end

    // One hour of ticks from reset: a single hour_tick on the last tick.
    step(1'b1, 1'b0, 1'b0, 1'b0, "hr_rst");
    ht_cnt = 0; ht_at = -1;
    for (int k = 1; k <= 3600; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, "hr_tick");
      if (hour_tick_o === 1'b1) begin ht_cnt++; ht_at = k; end
    end
    chk("hr_tick_count", ht_cnt, 1);
    chk("hr_tick_at", ht_at, 3600);
    chk_out("hr_final", 1, 0, 0, 0, 1, 1, 0);

    // Blink toggles on ticks in SET_HOUR; time frozen.
    step(1'b0, 1'b0, 1'b1, 1'b0, "blk_enter");
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, "blk_tick");
      chk($sformatf("blk_seq%0d", k), blink_o, bseq[k]);
    end
    chk_out("blk_time", 1, 0, 0, 1, 1, 0, 0);

    // Mode+inc in SET_HOUR, then tick+mode in RUN.
    step(1'b0, 1'b0, 1'b1, 1'b1, "mi_coinc");
    chk_out("mi_const", 1, 0, 0, 2, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "mi_run");
    step(1'b0, 1'b1, 1'b1, 1'b0, "tm_coinc");
    chk_out("tm_const", 1, 0, 1, 1, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "tm_min");
    step(1'b0, 1'b1, 1'b1, 1'b0, "tm_back");
    chk_out("tm_back_const", 1, 0, 0, 0, 1, 0, 0);

    // Midnight rollover from 23:59:58.
    step(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
    set_time(23, 59);
    for (int k = 0; k < 58; k++) step(1'b0, 1'b1, 1'b0, 1'b0, "mid_pre");
    chk_out("mid_2358", 23, 59, 58, 0, 1, 0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "mid_t1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "mid_t2");
    chk_out("mid_wrap", 0, 0, 0, 0, 1, 1, 1);

    // Set from 10:20:30 with wrapping increments.
    step(1'b1, 1'b0, 1'b0, 1'b0, "set_rst");
    set_time(10, 20);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 1'b0, 1'b0, "set_pre");
    chk_out("set_102030", 10, 20, 30, 0, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "set_m1");
    for (int k = 0; k < 15; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "set_h15");
    step(1'b0, 1'b0, 1'b1, 1'b0, "set_m2");
    for (int k = 0; k < 45; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "set_m45");
    chk_out("set_0105", 1, 5, 0, 2, 1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, "set_m3");
    chk("set_run_mode", mode_o, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, "set_resume");
    chk_out("set_010501", 1, 5, 1, 0, 1, 0, 0);

    // Reset in the middle of SET_MIN.
    step(1'b0, 1'b0, 1'b1, 1'b0, "rsm_m1");
    step(1'b0, 1'b0, 1'b1, 1'b0, "rsm_m2");
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "rsm_inc");
    chk("rsm_min7", min_o, 12);
    step(1'b1, 1'b0, 1'b0, 1'b1, "rsm_rst");
    chk_out("rsm_const", IH, IM, 0, 0, 1, 0, 0);

    // Random stimulus starting close to midnight.
    set_time(23, 58);
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
